// File: rtl/svm_pwm_out.sv
// Three-phase centre-aligned PWM modulator with double-buffered refs and per-leg dead time.
// Latency: a ref accepted takes effect at the next carrier boundary; gates follow the compare 1 clock later plus dead time.
// Backpressure: ref_ready is low while the pending buffer holds a ref not yet applied; nothing is dropped or overwritten.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   enable                  1 = modulate; 0 = gates low, carrier parked at the boundary
//   ref_valid / ref_ready   handshake for ref_a/b/c (Q4.28 signed phase voltage refs)
//   pwm_xh / pwm_xl         high/low-side gate per phase (x = a, b, c)
//   period_start            1-clock pulse on the first clock of each carrier
//   sat / sat_clr           sticky clamp flag and its clear (a same-cycle set wins)
module svm_pwm_out #(
   parameter int N        = 32,
   parameter int Q        = 28,
   parameter int CW       = 16,
   parameter int PERIOD   = 1000,
   parameter int DEADTIME = 20
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         ref_valid,
   output logic         ref_ready,
   input  logic [N-1:0] ref_a,
   input  logic [N-1:0] ref_b,
   input  logic [N-1:0] ref_c,
   output logic         pwm_ah,
   output logic         pwm_al,
   output logic         pwm_bh,
   output logic         pwm_bl,
   output logic         pwm_ch,
   output logic         pwm_cl,
   output logic         period_start,
   output logic         sat,
   input  logic         sat_clr
);

   localparam int PW  = Q + 2 + CW;              // product width for u * PERIOD
   localparam int DTW = $clog2(DEADTIME + 2);    // run length saturates at DEADTIME+1

   localparam logic signed [N-1:0] POS_ONE = N'(64'd1 << Q);
   localparam logic signed [N-1:0] NEG_ONE = -POS_ONE;
   localparam logic [CW-1:0]  PER_M1  = CW'(PERIOD - 1);
   localparam logic [CW-1:0]  CMP_MID = CW'(PERIOD / 2);
   localparam logic [DTW-1:0] DT_V    = DTW'(DEADTIME);
   localparam logic [DTW-1:0] DT_SAT  = DTW'(DEADTIME + 1);

   logic [CW-1:0]        cnt;
   logic                 dir_dn;
   logic                 live;        // low for the first clock after reset release
   logic                 run;
   logic                 boundary;
   logic                 pend_full;
   logic                 accept;
   logic [2:0][N-1:0]    ref_in;
   logic [2:0][CW-1:0]   cmp_new;
   logic [2:0][CW-1:0]   pend_cmp;
   logic [2:0][CW-1:0]   act_cmp;
   logic [2:0]           clip_v;
   logic [2:0]           gate_h;
   logic [2:0]           gate_l;

   // The carrier only runs once live is set, so a reset release with enable
   // already high still begins with a clean boundary clock and period_start
   // stays low for the whole time reset is asserted.
   assign run          = enable & live;
   assign boundary     = run & (cnt == '0) & ~dir_dn;
   assign period_start = boundary;
   assign ref_ready    = ~pend_full;
   assign accept       = ref_valid & ref_ready;
   assign ref_in       = {ref_c, ref_b, ref_a};

   // Triangle carrier: each endpoint is held for two clocks (once per direction).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         dir_dn <= 1'b0;
         live   <= 1'b0;
      end else begin
         live <= 1'b1;
         if (!run) begin
            cnt    <= '0;
            dir_dn <= 1'b0;
         end else if (!dir_dn) begin
            if (cnt == PER_M1) dir_dn <= 1'b1;
            else               cnt    <= cnt + CW'(1);
         end else begin
            if (cnt == '0) dir_dn <= 1'b0;
            else           cnt    <= cnt - CW'(1);
         end
      end
   end

   // Pending/active double buffer. An accept needs an empty pending slot, so it
   // never coincides with the boundary transfer out of a full slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend_full <= 1'b0;
         pend_cmp  <= '0;
         act_cmp   <= {3{CMP_MID}};
         sat       <= 1'b0;
      end else begin
         if (boundary && pend_full) begin
            act_cmp   <= pend_cmp;
            pend_full <= 1'b0;
         end else if (accept) begin
            pend_cmp  <= cmp_new;
            pend_full <= 1'b1;
         end
         if (accept && (|clip_v)) sat <= 1'b1;
         else if (sat_clr)        sat <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_ph
      logic signed [N-1:0] xc;
      logic                clip;
      logic [Q+1:0]        u;
      logic                raw;
      logic                raw_q;
      logic [DTW-1:0]      run_len;   // clocks raw has held its value, 0 = no history
      logic [DTW-1:0]      s_now;
      logic                h_q;
      logic                l_q;

      always_comb begin
         xc   = $signed(ref_in[gi]);
         clip = 1'b0;
         if ($signed(ref_in[gi]) > POS_ONE) begin
            xc   = POS_ONE;
            clip = 1'b1;
         end else if ($signed(ref_in[gi]) < NEG_ONE) begin
            xc   = NEG_ONE;
            clip = 1'b1;
         end
      end

      // Offset to 0..2^(Q+1), scale by PERIOD, truncate: compare range 0..PERIOD.
      assign u           = (Q+2)'(xc + POS_ONE);
      assign cmp_new[gi] = CW'((PW'(u) * PW'(PERIOD)) >> (Q + 1));
      assign clip_v[gi]  = clip;

      assign raw = (cnt < act_cmp[gi]);

      always_comb begin
         s_now = DTW'(1);
         if ((run_len != '0) && (raw == raw_q))
            s_now = (run_len == DT_SAT) ? run_len : run_len + DTW'(1);
      end

      // A gate follows raw only once raw has been stable for more than
      // DEADTIME clocks, so both gates sit low across every raw edge.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            raw_q   <= 1'b0;
            run_len <= '0;
            h_q     <= 1'b0;
            l_q     <= 1'b0;
         end else if (!run) begin
            raw_q   <= 1'b0;
            run_len <= '0;
            h_q     <= 1'b0;
            l_q     <= 1'b0;
         end else begin
            raw_q   <= raw;
            run_len <= s_now;
            h_q     <= raw & (s_now > DT_V);
            l_q     <= ~raw & (s_now > DT_V);
         end
      end

      assign gate_h[gi] = h_q;
      assign gate_l[gi] = l_q;
   end

   assign pwm_ah = gate_h[0];
   assign pwm_al = gate_l[0];
   assign pwm_bh = gate_h[1];
   assign pwm_bl = gate_l[1];
   assign pwm_ch = gate_h[2];
   assign pwm_cl = gate_l[2];

endmodule

// File: tb/tb_svm_pwm_out.sv
// Directed bench for svm_pwm_out with PERIOD=100, DEADTIME=5.
// Expected gate on-times are hand-derived: high side 2*cmp-5, low side 200-2*cmp-5 clocks per carrier.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_svm_pwm_out;
   localparam int N = 32, Q = 28, CW = 16, PERIOD = 100, DEADTIME = 5;

   logic         clock = 1'b0;
   logic         reset_n, enable, ref_valid, sat_clr;
   logic [N-1:0] ref_a, ref_b, ref_c;
   logic         ref_ready, period_start, sat;
   logic         pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;

   int checks = 0;
   int errors = 0;
   int n_ah, n_al, n_bh, n_bl, n_ch, n_cl, n_ps, n_ovl;
   int gap, stall, prev_ps;

   svm_pwm_out #(.N(N), .Q(Q), .CW(CW), .PERIOD(PERIOD), .DEADTIME(DEADTIME)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .ref_valid(ref_valid), .ref_ready(ref_ready),
      .ref_a(ref_a), .ref_b(ref_b), .ref_c(ref_c),
      .pwm_ah(pwm_ah), .pwm_al(pwm_al), .pwm_bh(pwm_bh), .pwm_bl(pwm_bl),
      .pwm_ch(pwm_ch), .pwm_cl(pwm_cl),
      .period_start(period_start), .sat(sat), .sat_clr(sat_clr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance to the next period_start; gap returns the clocks taken.
   task automatic wait_ps(input string tag, output int g);
      g = 0;
      do begin
         tick();
         g++;
      end while (!period_start && g < 500);
      check(tag, int'(period_start), 1);
   endtask

   task automatic measure(input int n);
      n_ah = 0; n_al = 0; n_bh = 0; n_bl = 0; n_ch = 0; n_cl = 0; n_ps = 0; n_ovl = 0;
      for (int i = 0; i < n; i++) begin
         n_ah  += int'(pwm_ah);  n_al += int'(pwm_al);
         n_bh  += int'(pwm_bh);  n_bl += int'(pwm_bl);
         n_ch  += int'(pwm_ch);  n_cl += int'(pwm_cl);
         n_ps  += int'(period_start);
         n_ovl += int'((pwm_ah & pwm_al) | (pwm_bh & pwm_bl) | (pwm_ch & pwm_cl));
         tick();
      end
   endtask

   task automatic send(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c);
      int k;
      ref_a = a; ref_b = b; ref_c = c;
      ref_valid = 1'b1;
      k = 0;
      while (!ref_ready && k < 500) begin
         tick();
         k++;
      end
      check(tag, int'(ref_ready), 1);
      tick();
      ref_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- T1: reset state, default cmp=50 ----
      reset_n = 1'b0; enable = 1'b1; ref_valid = 1'b0; sat_clr = 1'b0;
      ref_a = '0; ref_b = '0; ref_c = '0;
      #12;
      check("t1_rst_gates", int'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
      check("t1_rst_ps", int'(period_start), 0);
      check("t1_rst_ready", int'(ref_ready), 1);
      check("t1_rst_sat", int'(sat), 0);
      reset_n = 1'b1;
      tick();
      check("t1_first_ps", int'(period_start), 1);
      wait_ps("t1_ps", gap);
      check("t1_ps_gap", gap, 2 * PERIOD);
      measure(200);
      check("t1_ah", n_ah, 95);
      check("t1_al", n_al, 95);
      check("t1_ch", n_ch, 95);
      check("t1_ps_cnt", n_ps, 1);
      check("t1_ovl", n_ovl, 0);

      // ---- T2: a=+1.0 -> cmp 100 ----
      ticks(10);
      send("t2_send", 32'h1000_0000, 32'h0, 32'h0);
      check("t2_ready_low", int'(ref_ready), 0);
      wait_ps("t2_ps", gap);
      check("t2_ready_bnd", int'(ref_ready), 0);
      tick();
      check("t2_ready_back", int'(ref_ready), 1);
      wait_ps("t2_ps2", gap);
      measure(200);
      check("t2_ah", n_ah, 200);
      check("t2_al", n_al, 0);
      check("t2_bh", n_bh, 95);
      check("t2_sat", int'(sat), 0);

      // ---- T3: b=-1.0 -> cmp 0, c=0 -> cmp 50 ----
      ticks(10);
      send("t3_send", 32'h1000_0000, 32'hF000_0000, 32'h0);
      wait_ps("t3_ps", gap);
      wait_ps("t3_ps2", gap);
      measure(200);
      check("t3_ah", n_ah, 200);
      check("t3_bh", n_bh, 0);
      check("t3_bl", n_bl, 200);
      check("t3_ch", n_ch, 95);
      check("t3_cl", n_cl, 95);
      check("t3_ovl", n_ovl, 0);

      // ---- T4: a=+2.0 clamps to 100, b=+0.5 -> 75, c=-2^-28 truncates to 49 ----
      ticks(10);
      send("t4_send", 32'h2000_0000, 32'h0800_0000, 32'hFFFF_FFFF);
      check("t4_sat_set", int'(sat), 1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("t4_sat_clr", int'(sat), 0);
      wait_ps("t4_ps", gap);
      wait_ps("t4_ps2", gap);
      measure(200);
      check("t4_ah", n_ah, 200);
      check("t4_al", n_al, 0);
      check("t4_bh", n_bh, 145);
      check("t4_bl", n_bl, 45);
      check("t4_ch", n_ch, 93);
      check("t4_cl", n_cl, 97);
      check("t4_sat_hold", int'(sat), 0);

      // set on a clamped accept wins over a same-cycle clear (a=-2.0 -> cmp 0)
      ticks(10);
      ref_a = 32'hE000_0000; ref_b = 32'h0800_0000; ref_c = 32'hFFFF_FFFF;
      ref_valid = 1'b1;
      sat_clr = 1'b1;
      check("t4_wins_rdy", int'(ref_ready), 1);
      tick();
      ref_valid = 1'b0;
      sat_clr = 1'b0;
      check("t4_set_wins", int'(sat), 1);

      // ---- T5: back-to-back writes, second stalls until the boundary ----
      wait_ps("t5_ps0", gap);
      ticks(20);
      send("t5_send1", 32'h1000_0000, 32'h0800_0000, 32'hFFFF_FFFF);
      check("t5_stall_start", int'(ref_ready), 0);
      ref_a = 32'hF000_0000;
      ref_valid = 1'b1;
      stall = 0;
      prev_ps = 0;
      while (!ref_ready && stall < 500) begin
         prev_ps = int'(period_start);
         stall++;
         tick();
      end
      check("t5_stall_len", stall, 180);
      check("t5_ready_after_ps", prev_ps, 1);
      tick();
      ref_valid = 1'b0;
      ticks(48);
      check("t5_first_ah", int'(pwm_ah), 1);
      check("t5_first_al", int'(pwm_al), 0);
      check("t5_second_pending", int'(ref_ready), 0);
      wait_ps("t5_ps2", gap);
      ticks(50);
      check("t5_second_ah", int'(pwm_ah), 0);
      check("t5_second_al", int'(pwm_al), 1);
      check("t5_ready_free", int'(ref_ready), 1);

      // ---- T6: async reset mid-carrier, then enable toggles ----
      send("t6_send", 32'h0800_0000, 32'h0800_0000, 32'hFFFF_FFFF);
      wait_ps("t6_ps", gap);
      tick();
      send("t6_send_pend", 32'h1000_0000, 32'h0, 32'h0);
      ticks(35);
      check("t6_pre_ah", int'(pwm_ah), 1);
      check("t6_pre_pend", int'(ref_ready), 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_gates", int'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
      check("t6_rst_ready", int'(ref_ready), 1);
      check("t6_rst_sat", int'(sat), 0);
      check("t6_rst_ps", int'(period_start), 0);
      #10;
      reset_n = 1'b1;
      tick();
      check("t6_first_ps", int'(period_start), 1);
      wait_ps("t6_ps2", gap);
      check("t6_ps_gap", gap, 2 * PERIOD);
      measure(200);
      check("t6_ah", n_ah, 95);
      check("t6_al", n_al, 95);
      check("t6_bh", n_bh, 95);
      check("t6_ch", n_ch, 95);
      check("t6_ready", int'(ref_ready), 1);

      ticks(10);
      check("t6_on_ah", int'(pwm_ah), 1);
      enable = 1'b0;
      tick();
      check("t6_off_gates", int'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
      check("t6_off_ps", int'(period_start), 0);
      ticks(3);
      check("t6_off_hold", int'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
      enable = 1'b1;
      #1;
      check("t6_en_ps", int'(period_start), 1);
      ticks(5);
      check("t6_dt_gap", int'(pwm_ah | pwm_al), 0);
      tick();
      check("t6_dt_ah", int'(pwm_ah), 1);
      check("t6_dt_al", int'(pwm_al), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
